// File: rtl/crc_module.sv
`default_nettype none
// ============================================================================
// Module   : crc_module
// Summary  : Byte-serial CRC-16 generator, one byte per clock, CCITT-FALSE default.
// Revision : 1.0 - initial release
// ============================================================================
module crc_module #(
  parameter logic [15:0] POLY   = 16'h1021,
  parameter logic [15:0] INIT   = 16'hFFFF,
  parameter logic [15:0] XOROUT = 16'h0000,
  parameter bit          REFIN  = 1'b0,
  parameter bit          REFOUT = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vld,
  input  logic [7:0]  din,
  output logic [15:0] crc_dout
);

  logic [15:0] r_crc;
  logic [7:0]  w_byte;
  logic [15:0] w_crc_next;
  logic [15:0] w_crc_ref;

  // Input byte ordering: reflected configs consume the byte LSB-first.
  generate
    if (REFIN) begin : g_refin
      for (genvar i = 0; i < 8; i++) begin : g_rev8
        assign w_byte[i] = din[7-i];
      end
    end else begin : g_no_refin
      assign w_byte = din;
    end
  endgenerate

  // Eight unrolled MSB-first shift/XOR steps form the whole byte update.
  always_comb begin
    w_crc_next = r_crc ^ {w_byte, 8'h00};
    for (int k = 0; k < 8; k++) begin
      if (w_crc_next[15]) begin
        w_crc_next = (w_crc_next << 1) ^ POLY;
      end else begin
        w_crc_next = w_crc_next << 1;
      end
    end
  end

  // din is only consumed when vld is high, so idle-cycle X never reaches r_crc.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_crc <= INIT;
    end else if (vld) begin
      r_crc <= w_crc_next;
    end
  end

  generate
    if (REFOUT) begin : g_refout
      for (genvar j = 0; j < 16; j++) begin : g_rev16
        assign w_crc_ref[j] = r_crc[15-j];
      end
    end else begin : g_no_refout
      assign w_crc_ref = r_crc;
    end
  endgenerate

  assign crc_dout = w_crc_ref ^ XOROUT;

endmodule
`default_nettype wire

// File: tb/tb_crc_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_module
// Summary  : Directed self-checking bench for crc_module (CCITT-FALSE and KERMIT).
// Revision : 1.0 - initial release
// ============================================================================
module tb_crc_module;

  logic        clk;
  logic        reset_n;
  logic        vld;
  logic [7:0]  din;
  logic [15:0] crc_dout;
  logic [15:0] crc_kermit;

  int n_checks;
  int n_fail;

  crc_module u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .vld      (vld),
    .din      (din),
    .crc_dout (crc_dout)
  );

  crc_module #(
    .POLY   (16'h1021),
    .INIT   (16'h0000),
    .XOROUT (16'h0000),
    .REFIN  (1'b1),
    .REFOUT (1'b1)
  ) u_dut_kermit (
    .clk      (clk),
    .reset_n  (reset_n),
    .vld      (vld),
    .din      (din),
    .crc_dout (crc_kermit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Bit-at-a-time reference for CCITT-FALSE, used for intermediate values.
  function automatic logic [15:0] ref_bit_crc(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int k = 7; k >= 0; k--) begin
      fb = r[15] ^ b[k];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    vld = v;
    din = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    vld     = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [7:0]  msg [9];
  logic [15:0] model;
  int          gaps;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    reset_n = 1'b0;
    vld     = 1'b0;
    din     = 8'h00;

    // Reset held three cycles, with reset priority over vld on the last one.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", crc_dout, 16'hFFFF);
      check("reset_hold_kermit", crc_kermit, 16'h0000);
      vld = (i == 2);
      din = 8'h55;
    end
    @(negedge clk);
    check("reset_priority", crc_dout, 16'hFFFF);
    vld     = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", crc_dout, 16'hFFFF);

    // Single byte then idle.
    drive(1'b1, 8'h55);
    drive(1'b0, 8'hA3);
    check("single_55", crc_dout, 16'hEBA0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'(i * 37 + 5));
      check("single_idle", crc_dout, 16'hEBA0);
    end

    // Check string on consecutive cycles, both configurations.
    do_reset();
    for (int i = 0; i < 9; i++) drive(1'b1, msg[i]);
    drive(1'b0, 8'h00);
    check("check_string", crc_dout, 16'h29B1);
    check("kermit_string", crc_kermit, 16'h2189);

    // Gapped stream with random din during gaps.
    do_reset();
    model = 16'hFFFF;
    for (int i = 0; i < 9; i++) begin
      gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) begin
        drive(1'b0, 8'($urandom));
        @(posedge clk);
        #1;
        check("gap_hold", crc_dout, model);
      end
      drive(1'b1, msg[i]);
      model = ref_bit_crc(model, msg[i]);
    end
    drive(1'b0, 8'($urandom));
    check("gapped_final", crc_dout, 16'h29B1);
    check("gapped_model", crc_dout, model);

    // Asynchronous reset mid-stream.
    do_reset();
    model = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, msg[i]);
      model = ref_bit_crc(model, msg[i]);
    end
    @(negedge clk);
    vld = 1'b0;
    check("midstream_partial", crc_dout, model);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", crc_dout, 16'hFFFF);
    check("async_reset_kermit", crc_kermit, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 8'h55);
    drive(1'b0, 8'h00);
    check("restart_55", crc_dout, 16'hEBA0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
